// File: rtl/register_file_mw_nr_be_clr.sv
// ---------------------------------------------------------------------------
// register_file_mw_nr_be_clr
//   Latch-based register file / scratchpad with N_WRITE byte-enabled write
//   ports, N_READ registered-address read ports and a hardware clear
//   sequencer that zeroes the array after reset or on request.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   ReadEnable       per read port: capture ReadAddr at posedge
//   ReadAddr         read addresses, port z at [z*ADDR_WIDTH +: ADDR_WIDTH]
//   ReadData         read data for the last captured address (0 while busy)
//   WriteEnable      per write port request
//   WriteAddr        write addresses
//   WriteData        write data
//   WriteBE          byte enables, port i at [i*NUM_BYTE +: NUM_BYTE]
//   clear_i          single-cycle request to zero the whole array
//   busy_o           clear sequence in progress
// ---------------------------------------------------------------------------
module register_file_mw_nr_be_clr #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int N_READ         = 2,
    parameter int N_WRITE        = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_READ-1:0]                ReadEnable,
    input  logic [N_READ*ADDR_WIDTH-1:0]     ReadAddr,
    output logic [N_READ*DATA_WIDTH-1:0]     ReadData,
    input  logic [N_WRITE-1:0]               WriteEnable,
    input  logic [N_WRITE*ADDR_WIDTH-1:0]    WriteAddr,
    input  logic [N_WRITE*DATA_WIDTH-1:0]    WriteData,
    input  logic [N_WRITE*DATA_WIDTH/8-1:0]  WriteBE,
    input  logic                             clear_i,
    output logic                             busy_o
);

    localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTE  = DATA_WIDTH / 8;

    typedef enum logic {ST_IDLE, ST_CLR} state_e;
    localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLR : ST_IDLE;

    state_e                                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]                         cnt_q, cnt_d;
    logic                                          clr_we_q, clr_we_d;
    logic [ADDR_WIDTH-1:0]                         clr_addr_q, clr_addr_d;
    logic [N_WRITE-1:0][NUM_BYTE-1:0]              wr_en_q, wr_en_d;
    logic [N_WRITE-1:0][ADDR_WIDTH-1:0]            wr_addr_q, wr_addr_d;
    logic [N_WRITE-1:0][DATA_WIDTH-1:0]            wr_data_q, wr_data_d;
    logic [N_READ-1:0][ADDR_WIDTH-1:0]             rd_addr_q, rd_addr_d;
    logic [N_READ-1:0]                             rd_fresh_q, rd_fresh_d;

    logic                                          cg_en_d, cg_en_l, gclk;
    logic [NUM_WORDS-1:0][NUM_BYTE-1:0]            byte_we;
    logic [NUM_WORDS-1:0][NUM_BYTE-1:0][7:0]       byte_wd;
    logic [7:0]                                    mem_l [NUM_WORDS][NUM_BYTE];
    logic [7:0]                                    rbyte;

    // ---- Stage boundary: request sampling registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            clr_we_q   <= 1'b0;
            clr_addr_q <= '0;
            wr_en_q    <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_fresh_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_we_q   <= clr_we_d;
            clr_addr_q <= clr_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_fresh_q <= rd_fresh_d;
        end
    end

    // Clear sequencer next state: one word per cycle, word index = counter.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_we_d   = 1'b0;
        clr_addr_d = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            ST_CLR: begin
                clr_we_d = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_CLR);
    end

    // Per-byte priority: a byte is dropped if any higher-index port writes the
    // same byte of the same word. Everything is dropped while clearing.
    always_comb begin
        wr_en_d   = '0;
        wr_addr_d = '0;
        wr_data_d = '0;
        for (int i = 0; i < N_WRITE; i++) begin
            wr_addr_d[i] = WriteAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            wr_data_d[i] = WriteData[i*DATA_WIDTH +: DATA_WIDTH];
            for (int b = 0; b < NUM_BYTE; b++) begin
                wr_en_d[i][b] = WriteEnable[i] && WriteBE[i*NUM_BYTE+b] && !busy_o;
                for (int j = i + 1; j < N_WRITE; j++) begin
                    if (WriteEnable[j] && WriteBE[j*NUM_BYTE+b] &&
                        (WriteAddr[j*ADDR_WIDTH +: ADDR_WIDTH] == wr_addr_d[i])) begin
                        wr_en_d[i][b] = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_addr_d  = rd_addr_q;
        rd_fresh_d = ReadEnable;
        for (int z = 0; z < N_READ; z++) begin
            if (ReadEnable[z]) begin
                rd_addr_d[z] = ReadAddr[z*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Clock gate: enable is latched in the low phase from the values about to
    // be sampled, so the gated high phase right after the edge carries them.
    assign cg_en_d = (|wr_en_d) || clr_we_d;

    always_latch begin
        if (!clk) begin
            cg_en_l <= cg_en_d;
        end
    end

    assign gclk = clk & cg_en_l;

    // Word/byte decode of the sampled writes into latch enables.
    always_comb begin
        byte_we = '0;
        byte_wd = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (clr_we_q && (clr_addr_q == ADDR_WIDTH'(w))) begin
                    byte_we[w][b] = 1'b1;
                    byte_wd[w][b] = '0;
                end
                for (int i = 0; i < N_WRITE; i++) begin
                    if (wr_en_q[i][b] && (wr_addr_q[i] == ADDR_WIDTH'(w))) begin
                        byte_we[w][b] = 1'b1;
                        byte_wd[w][b] = wr_data_q[i][b*8 +: 8];
                    end
                end
            end
        end
    end

    // ---- Stage boundary: latch array, transparent in the gated high phase ----
    always_latch begin
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (gclk && byte_we[w][b]) begin
                    mem_l[w][b] <= byte_wd[w][b];
                end
            end
        end
    end

    // Read mux. A read captured on the same edge as a write to that byte
    // takes the sampled write data so the value is clean for the whole cycle.
    always_comb begin
        ReadData = '0;
        rbyte    = '0;
        for (int z = 0; z < N_READ; z++) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                rbyte = mem_l[rd_addr_q[z]][b];
                if (rd_fresh_q[z]) begin
                    if (clr_we_q && (clr_addr_q == rd_addr_q[z])) begin
                        rbyte = '0;
                    end
                    for (int i = 0; i < N_WRITE; i++) begin
                        if (wr_en_q[i][b] && (wr_addr_q[i] == rd_addr_q[z])) begin
                            rbyte = wr_data_q[i][b*8 +: 8];
                        end
                    end
                end
                if (busy_o) begin
                    rbyte = '0;
                end
                ReadData[z*DATA_WIDTH + b*8 +: 8] = rbyte;
            end
        end
    end

endmodule

// File: tb/tb_register_file_mw_nr_be_clr.sv
module tb_register_file_mw_nr_be_clr;

    logic        clk;
    logic        rst_n;
    logic [1:0]  ReadEnable;
    logic [9:0]  ReadAddr;
    logic [63:0] ReadData;
    logic [1:0]  WriteEnable;
    logic [9:0]  WriteAddr;
    logic [63:0] WriteData;
    logic [7:0]  WriteBE;
    logic        clear_i;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    logic [1:0]  chk;
    logic [1:0]  chk_s;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    register_file_mw_nr_be_clr #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .N_READ(2), .N_WRITE(2), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ReadEnable(ReadEnable), .ReadAddr(ReadAddr), .ReadData(ReadData),
        .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .WriteBE(WriteBE), .clear_i(clear_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Monitor: a port marked for checking at an edge is compared mid-cycle
    // against the next expectation queued for that port.
    initial begin
        forever begin
            @(posedge clk);
            chk_s = chk;
            @(negedge clk);
            for (int z = 0; z < 2; z++) begin
                if (chk_s[z]) begin
                    if ((z == 0 && q0.size() == 0) || (z == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL rd_p%0d_no_expectation actual=%h expected=queued", z, ReadData[z*32 +: 32]);
                    end else if (z == 0) begin
                        check($sformatf("rd_p0@%0t", $time), ReadData[31:0], q0.pop_front());
                    end else begin
                        check($sformatf("rd_p1@%0t", $time), ReadData[63:32], q1.pop_front());
                    end
                end
            end
        end
    end

    task automatic push(input int p, input logic [31:0] e);
        if (p == 0) q0.push_back(e);
        else        q1.push_back(e);
        chk[p] = 1'b1;
    endtask

    task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        WriteEnable[p]       = 1'b1;
        WriteAddr[p*5 +: 5]  = a;
        WriteData[p*32 +: 32] = d;
        WriteBE[p*4 +: 4]    = be;
    endtask

    task automatic rd(input int p, input logic [4:0] a, input logic [31:0] e);
        ReadEnable[p]      = 1'b1;
        ReadAddr[p*5 +: 5] = a;
        push(p, e);
    endtask

    task automatic hold(input int p, input logic [4:0] a, input logic [31:0] e);
        ReadEnable[p]      = 1'b0;
        ReadAddr[p*5 +: 5] = a;
        push(p, e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ReadEnable  = '0;
        WriteEnable = '0;
        WriteBE     = '0;
        clear_i     = 1'b0;
        chk         = '0;
    endtask

    // Counts consecutive mid-cycle samples with busy_o high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (busy_o) n++;
            else break;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_zero();
        for (int w = 0; w < 32; w++) begin
            rd(0, 5'(w), 32'h0);
            rd(1, 5'(31 - w), 32'h0);
            step();
        end
    endtask

    int nb;

    initial begin
        rst_n = 1'b0; ReadEnable = '0; ReadAddr = '0; WriteEnable = '0;
        WriteAddr = '0; WriteData = '0; WriteBE = '0; clear_i = 1'b0; chk = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy_o}, 32'd1);
        check("reset_rdata", ReadData[31:0], 32'h0);
        rst_n = 1'b1;

        // 1: clear after reset lasts 32 cycles, array reads zero
        count_busy(nb);
        check("rst_clear_cycles", nb, 32);
        read_all_zero();

        // 2: full write, same-edge forwarding then array read
        wr(0, 5'd3, 32'hDEADBEEF, 4'hF);
        rd(0, 5'd3, 32'hDEADBEEF);
        step();
        rd(1, 5'd3, 32'hDEADBEEF);
        step();

        // 3: same-address collision, per-byte merge
        wr(0, 5'd7, 32'h11111111, 4'hF);
        wr(1, 5'd7, 32'h22222222, 4'h3);
        rd(0, 5'd7, 32'h11112222);
        step();
        rd(1, 5'd7, 32'h11112222);
        step();

        // Full collision: port1 wins every byte
        wr(0, 5'd31, 32'h01020304, 4'hF);
        wr(1, 5'd31, 32'hCAFEF00D, 4'hF);
        rd(1, 5'd31, 32'hCAFEF00D);
        step();
        rd(0, 5'd31, 32'hCAFEF00D);
        step();

        // Two ports, different words; word 0 boundary
        wr(0, 5'd0, 32'h0BADC0DE, 4'hF);
        wr(1, 5'd10, 32'h9ABCDEF0, 4'hF);
        step();
        rd(0, 5'd10, 32'h9ABCDEF0);
        rd(1, 5'd0, 32'h0BADC0DE);
        step();

        // 4: partial byte write, then hold with ReadEnable low
        wr(0, 5'd5, 32'hAABBCCDD, 4'hF);
        step();
        wr(1, 5'd5, 32'h000000EE, 4'h1);
        rd(0, 5'd5, 32'hAABBCCEE);
        step();
        hold(0, 5'd3, 32'hAABBCCEE);
        rd(1, 5'd5, 32'hAABBCCEE);
        step();
        hold(0, 5'd7, 32'hAABBCCEE);
        step();

        // 5: clear request with a write pending; writes during clear dropped
        clear_i = 1'b1;
        wr(0, 5'd12, 32'h55555555, 4'hF);
        step();
        nb = 0;
        for (int k = 0; k < 32; k++) begin
            wr(0, 5'd20, 32'hFFFFFFFF, 4'hF);
            wr(1, 5'd21, 32'h12345678, 4'hF);
            clear_i = 1'b1;
            rd(1, 5'd3, 32'h0);
            @(negedge clk);
            if (busy_o) nb++;
            step();
        end
        check("clr_busy_after", {31'd0, busy_o}, 32'd0);
        check("clr_cycles", nb, 32);
        read_all_zero();

        // 6: reset mid-clear at counter 10 restarts full clear
        wr(0, 5'd9, 32'h600DF00D, 4'hF);
        step();
        clear_i = 1'b1;
        step();
        repeat (10) step();
        rst_n = 1'b0;
        #2;
        check("midclr_reset_busy", {31'd0, busy_o}, 32'd1);
        step();
        step();
        rst_n = 1'b1;
        count_busy(nb);
        check("midclr_restart_cycles", nb, 32);
        rd(0, 5'd9, 32'h0);
        rd(1, 5'd31, 32'h0);
        step();

        // Normal operation after restart
        wr(1, 5'd17, 32'h13572468, 4'hC);
        rd(0, 5'd17, 32'h13570000);
        step();
        rd(1, 5'd17, 32'h13570000);
        step();

        repeat (3) step();
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
